// File: rtl/histo_frame_sched.sv
// histo_frame_sched
//   Runs the pixel histogram engine through alternating acquire and readout
//   phases, one sensor frame at a time. During acquire, the engine accumulates
//   (histo_rw=1). During readout, it is swept bin by bin in read/clear mode, and
//   each count is streamed out behind a header word.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            level: schedule new acquisitions
//   skip_frames       frames ignored between acquisitions
//   frame_valid,
//   line_valid        sensor timing
//   histo_rw          engine mode: 1 accumulate, 0 read/clear
//   histo_bin         engine bin address during readout
//   histo_data        engine count for the addressed bin
//   out_data/valid/
//   ready/last        packet stream: header followed by NBINS count words
//   busy              not idle
//   frame_id          completed acquisitions (wraps)
//   err_mismatch      sticky: sum of bin counts differs from the pixel count
//   missed_frames     saturating count of frame starts lost to readout
module histo_frame_sched #(
  parameter int         NBINS   = 1024,
  parameter int         RD_LAT  = 4,
  parameter int         SETTLE  = 6,
  parameter logic [7:0] HDR_TAG = 8'hA5,
  parameter int         BW      = $clog2(NBINS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    skip_frames,
  input  logic          frame_valid,
  input  logic          line_valid,
  output logic          histo_rw,
  output logic [BW-1:0] histo_bin,
  input  logic [23:0]   histo_data,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic [15:0]   frame_id,
  output logic          err_mismatch,
  output logic [7:0]    missed_frames
);

  localparam int CMAX = (SETTLE > RD_LAT) ? SETTLE : RD_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ACQ, S_SETTLE, S_HDR, S_RD
  } state_t;

  state_t          state_q, state_d;
  logic            fv_q, fv_d;
  logic [7:0]      skip_q, skip_d;
  logic [31:0]     pix_q, pix_d;
  logic [31:0]     sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [15:0]     frame_id_q, frame_id_d;
  logic            err_q, err_d;
  logic [7:0]      missed_q, missed_d;

  logic fstart, fend, xfer, readout;

  always_comb begin
    state_d     = state_q;
    fv_d        = frame_valid;
    skip_d      = skip_q;
    pix_d       = pix_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_id_d  = frame_id_q;
    err_d       = err_q;
    missed_d    = missed_q;

    fstart  = frame_valid & ~fv_q;
    fend    = ~frame_valid & fv_q;
    xfer    = out_valid_q & out_ready;
    readout = (state_q == S_SETTLE) || (state_q == S_HDR) || (state_q == S_RD);

    // Frames that start while the engine is busy reading out are lost; count them.
    if (readout && fstart && (missed_q != 8'hFF))
      missed_d = missed_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ARM;
          skip_d  = skip_frames;
        end
      end
      S_ARM: begin
        // Only a fresh rising edge arms acquisition, so a frame already in
        // flight on entry is never half-captured.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (fstart) begin
          if (skip_q != 8'd0) begin
            skip_d = skip_q - 8'd1;
          end else begin
            state_d = S_ACQ;
            pix_d   = '0;
            sum_d   = '0;
          end
        end
      end
      S_ACQ: begin
        if (line_valid && frame_valid)
          pix_d = pix_q + 32'd1;
        if (fend) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          bin_d   = '0;
        end
      end
      S_SETTLE: begin
        // Let the engine's rw pipeline drain before the first read address.
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d     = S_HDR;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = {HDR_TAG, frame_id_q, 8'h00};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HDR: begin
        if (xfer) begin
          state_d     = S_RD;
          out_valid_d = 1'b0;
          bin_d       = '0;
          cnt_d       = '0;
        end
      end
      S_RD: begin
        if (!out_valid_q) begin
          // Wait out the engine read latency for the current bin address.
          if (cnt_q == CW'(RD_LAT)) begin
            out_valid_d = 1'b1;
            out_data_d  = {8'h00, histo_data};
            out_last_d  = (bin_q == BW'(NBINS - 1));
            sum_d       = sum_q + {8'h00, histo_data};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            frame_id_d = frame_id_q + 16'd1;
            if (sum_q != pix_q)
              err_d = 1'b1;
            bin_d = '0;
            if (enable) begin
              state_d = S_ARM;
              skip_d  = skip_frames;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bin_d = bin_q + 1'b1;
            cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fv_q        <= 1'b0;
      skip_q      <= '0;
      pix_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_id_q  <= '0;
      err_q       <= 1'b0;
      missed_q    <= '0;
    end else begin
      state_q     <= state_d;
      fv_q        <= fv_d;
      skip_q      <= skip_d;
      pix_q       <= pix_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_id_q  <= frame_id_d;
      err_q       <= err_d;
      missed_q    <= missed_d;
    end
  end

  // Engine stays in accumulate mode everywhere except settle and readout.
  assign histo_rw      = !((state_q == S_SETTLE) || (state_q == S_HDR) || (state_q == S_RD));
  assign histo_bin     = bin_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_id      = frame_id_q;
  assign err_mismatch  = err_q;
  assign missed_frames = missed_q;

endmodule

// File: tb/tb_histo_frame_sched.sv
module tb_histo_frame_sched;
  localparam int NB = 1024;

  logic        clk = 1'b0;
  logic        rst, enable, frame_valid, line_valid, out_ready;
  logic [7:0]  skip_frames;
  logic        histo_rw, out_valid, out_last, busy, err_mismatch;
  logic [9:0]  histo_bin;
  logic [23:0] histo_data;
  logic [31:0] out_data;
  logic [15:0] frame_id;
  logic [7:0]  missed_frames;

  always #5 clk = ~clk;

  histo_frame_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .skip_frames(skip_frames),
    .frame_valid(frame_valid), .line_valid(line_valid),
    .histo_rw(histo_rw), .histo_bin(histo_bin), .histo_data(histo_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .frame_id(frame_id),
    .err_mismatch(err_mismatch), .missed_frames(missed_frames)
  );

  // Engine model: bin address to count in four register stages.
  logic [23:0] mem [NB];
  logic [9:0]  p1, p2, p3;
  always @(posedge clk) begin
    p1 <= histo_bin;
    p2 <= p1;
    p3 <= p2;
    histo_data <= mem[p3];
  end

  typedef struct packed { logic [31:0] d; logic last; } word_t;
  word_t sb[$];

  typedef struct {
    logic [7:0] skip;
    int         rmode;
    int         pat;
    int         exp_fid;
    logic       exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int rmode  = 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor: drives ready, pops the scoreboard on transfers, and checks
  // that a stalled word and its bin address do not move.
  logic        hold = 1'b0;
  logic [9:0]  hbin;
  logic [31:0] hdat;
  initial begin
    word_t w;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold && !rst) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_bin", {22'd0, histo_bin}, {22'd0, hbin});
        chk("hold_data", out_data, hdat);
      end
      case (rmode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 3);
      endcase
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected no word", out_data);
        end else begin
          w = sb.pop_front();
          chk("word_data", out_data, w.d);
          chk("word_last", {31'd0, out_last}, {31'd0, w.last});
        end
      end
      hold = out_valid && !out_ready && !rst;
      hbin = histo_bin;
      hdat = out_data;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pat(int p);
    for (int b = 0; b < NB; b++) begin
      if (p == 1)         mem[b] = 24'd1;
      else if (b < 7)     mem[b] = 24'(b + 1);
      else if (b == 1000) mem[b] = 24'd4;   // 28 + 4 = 32 pixels
      else                mem[b] = 24'd0;
    end
  endtask

  task automatic push_pkt(logic [15:0] fid);
    sb.push_back({{8'hA5, fid, 8'h00}, 1'b0});
    for (int b = 0; b < NB; b++)
      sb.push_back({{8'h00, mem[b]}, (b == NB - 1)});
  endtask

  // rwchk: 0 none, 1 expect rw low one cycle after the fall, 2 expect it stays high
  task automatic send_frame(int lines, int px, int rwchk);
    frame_valid = 1'b1;
    cyc(3);
    for (int l = 0; l < lines; l++) begin
      line_valid = 1'b1;
      cyc(px);
      line_valid = 1'b0;
      cyc(2);
    end
    frame_valid = 1'b0;
    if (rwchk != 0) chk("rw_at_fall", {31'd0, histo_rw}, 32'd1);
    cyc(1);
    if (rwchk == 1) chk("rw_low_after_fall", {31'd0, histo_rw}, 32'd0);
    if (rwchk == 2) chk("rw_high_skipped", {31'd0, histo_rw}, 32'd1);
    cyc(2);
  endtask

  task automatic wait_done(int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL packet_timeout: %0d words outstanding, expected 0", sb.size());
      sb.delete();
    end else begin
      chk("valid_after_pkt", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t tv[3];
    int   n;
    tv[0] = '{skip: 8'd0, rmode: 1, pat: 0, exp_fid: 1, exp_err: 1'b0};
    tv[1] = '{skip: 8'd2, rmode: 2, pat: 0, exp_fid: 2, exp_err: 1'b0};
    tv[2] = '{skip: 8'd0, rmode: 1, pat: 1, exp_fid: 3, exp_err: 1'b1};

    rst = 1'b1; enable = 1'b0; skip_frames = 8'd0;
    frame_valid = 1'b0; line_valid = 1'b0;
    set_pat(0);
    cyc(3);
    chk("rst_rw", {31'd0, histo_rw}, 32'd1);
    chk("rst_bin", {22'd0, histo_bin}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fid", {16'd0, frame_id}, 32'd0);
    chk("rst_err", {31'd0, err_mismatch}, 32'd0);
    chk("rst_missed", {24'd0, missed_frames}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      enable = 1'b0;
      cyc(3);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      skip_frames = tv[i].skip;
      rmode = tv[i].rmode;
      set_pat(tv[i].pat);
      enable = 1'b1;
      cyc(2);
      chk("arm_busy", {31'd0, busy}, 32'd1);
      for (int f = 0; f <= int'(tv[i].skip); f++) begin
        if (f == int'(tv[i].skip)) begin
          push_pkt(16'(tv[i].exp_fid - 1));
          send_frame(4, 8, 1);
        end else begin
          send_frame(4, 8, 2);
        end
      end
      wait_done(20000);
      chk("pkt_fid", {16'd0, frame_id}, 32'(tv[i].exp_fid));
      chk("pkt_err", {31'd0, err_mismatch}, {31'd0, tv[i].exp_err});
    end

    // Frame starts during a stalled readout are counted, readout continues.
    rmode = 0;
    set_pat(0);
    push_pkt(16'd3);
    send_frame(4, 8, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hdr_appeared", {31'd0, out_valid}, 32'd1);
    send_frame(1, 2, 0);
    send_frame(1, 2, 0);
    chk("missed_two", {24'd0, missed_frames}, 32'd2);
    cyc(5);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_rw", {31'd0, histo_rw}, 32'd0);
    rmode = 1;
    wait_done(20000);
    chk("missed_fid", {16'd0, frame_id}, 32'd4);
    chk("err_sticky", {31'd0, err_mismatch}, 32'd1);
    chk("missed_hold", {24'd0, missed_frames}, 32'd2);

    // Reset in the middle of readout.
    push_pkt(16'd4);
    send_frame(4, 8, 1);
    n = 0;
    while (!(out_valid && histo_bin == 10'd500) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bin500", {22'd0, histo_bin}, 32'd500);
    rst = 1'b1;
    cyc(1);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_rw", {31'd0, histo_rw}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_last", {31'd0, out_last}, 32'd0);
    chk("mrst_fid", {16'd0, frame_id}, 32'd0);
    chk("mrst_err", {31'd0, err_mismatch}, 32'd0);
    chk("mrst_missed", {24'd0, missed_frames}, 32'd0);
    rst = 1'b0;
    sb.delete();
    cyc(3);
    push_pkt(16'd0);
    send_frame(4, 8, 1);
    wait_done(20000);
    chk("post_rst_fid", {16'd0, frame_id}, 32'd1);
    chk("post_rst_err", {31'd0, err_mismatch}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
